cu_launcher: RTL

CU_LAUNCHER -- requirements
Module: cu_launcher

---
 rtl/cu_pkg.sv | 20 ++
 rtl/cu_launcher_if.sv | 28 ++
 rtl/cu_launcher_sat_counter.sv | 14 +
 rtl/cu_launcher.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the CU launcher: FSM states, completion status codes
// and the counter/seed widths the CU itself is built with.
package cu_pkg;
  localparam int CTR_WIDTH_DEF = 16;
  localparam int RND_WIDTH_DEF = 16;
  localparam int CYC_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_RUN,
    S_REPORT
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;
  localparam logic [1:0] ST_REJECT  = 2'b11;
endpackage

// File: rtl/cu_launcher_if.sv
// Host-side config request and completion handshakes of the CU launcher.
interface cu_launcher_if
  import cu_pkg::*;
#(
  parameter int CTR_WIDTH = CTR_WIDTH_DEF,
  parameter int RND_WIDTH = RND_WIDTH_DEF,
  parameter int CYC_WIDTH = CYC_WIDTH_DEF
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 cfg_mode;
  logic [CTR_WIDTH-1:0] cfg_max_step;
  logic [CTR_WIDTH-1:0] cfg_max_episode;
  logic [RND_WIDTH-1:0] cfg_seed;
  logic                 done_valid;
  logic                 done_ready;
  logic [1:0]           done_status;
  logic [CYC_WIDTH-1:0] done_cycles;

  modport master (
    output cfg_valid, cfg_mode, cfg_max_step, cfg_max_episode, cfg_seed, done_ready,
    input  cfg_ready, done_valid, done_status, done_cycles
  );
  modport slave (
    input  cfg_valid, cfg_mode, cfg_max_step, cfg_max_episode, cfg_seed, done_ready,
    output cfg_ready, done_valid, done_status, done_cycles
  );
endinterface

// File: rtl/cu_launcher_sat_counter.sv
// Clearable, enabled up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)                 q <= '0;
    else if (en && q != '1)  q <= q + WIDTH'(1);
  end
endmodule

// File: rtl/cu_launcher.sv
// Launches one CU run per accepted config, watches finish/abort/timeout and
// reports a status plus the number of cycles run was held high.
module cu_launcher
  import cu_pkg::*;
#(
  parameter int CTR_WIDTH      = CTR_WIDTH_DEF,
  parameter int RND_WIDTH      = RND_WIDTH_DEF,
  parameter int CYC_WIDTH      = CYC_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                 clk,
  input  logic                 rst,
  cu_launcher_if.slave         host,
  output logic                 run,
  output logic                 mode,
  output logic [CTR_WIDTH-1:0] max_step,
  output logic [CTR_WIDTH-1:0] max_episode,
  output logic [RND_WIDTH-1:0] seed,
  input  logic                 cu_idle,
  input  logic                 cu_finish,
  input  logic                 abort,
  output logic                 busy
);
  // The counter already holds N-1 on the Nth run cycle, so stop there.
  localparam logic [CYC_WIDTH-1:0] TO_LAST = CYC_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e               state, state_n;
  logic [1:0]           status_q, status_n;
  logic [CYC_WIDTH-1:0] cyc;
  logic                 xfer, cfg_zero, cfg_ready, done_valid;

  assign xfer     = host.cfg_valid && cfg_ready;
  assign cfg_zero = (host.cfg_max_step == '0) || (host.cfg_max_episode == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      status_q <= ST_OK;
    end else begin
      state    <= state_n;
      status_q <= status_n;
    end
  end

  always_comb begin
    state_n  = state;
    status_n = status_q;
    case (state)
      S_IDLE:
        if (xfer) begin
          if (cfg_zero) begin
            state_n  = S_REPORT;
            status_n = ST_REJECT;
          end else begin
            state_n  = S_LAUNCH;
          end
        end
      S_LAUNCH: state_n = S_WAIT_START;
      S_WAIT_START:
        if (abort) begin
          state_n  = S_REPORT;
          status_n = ST_ABORT;
        end else if (!cu_idle) begin
          state_n  = S_RUN;
        end
      S_RUN:
        if (cu_finish) begin
          state_n  = S_REPORT;
          status_n = ST_OK;
        end else if (abort) begin
          state_n  = S_REPORT;
          status_n = ST_ABORT;
        end else if (cyc >= TO_LAST) begin
          state_n  = S_REPORT;
          status_n = ST_TIMEOUT;
        end
      S_REPORT: if (host.done_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    run        = 1'b0;
    busy       = 1'b1;
    cfg_ready  = 1'b0;
    done_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cfg_ready = cu_idle && !rst;
      end
      S_WAIT_START, S_RUN: run = 1'b1;
      S_REPORT:            done_valid = 1'b1;
      default: ;
    endcase
  end

  assign host.cfg_ready   = cfg_ready;
  assign host.done_valid  = done_valid;
  assign host.done_status = status_q;
  assign host.done_cycles = cyc;

  // Drive registers only load on a transfer, so host-side changes mid-run are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= 1'b0;
      max_step    <= '0;
      max_episode <= '0;
      seed        <= '0;
    end else if (xfer) begin
      mode        <= host.cfg_mode;
      max_step    <= host.cfg_max_step;
      max_episode <= host.cfg_max_episode;
      seed        <= host.cfg_seed;
    end
  end

  sat_counter #(.WIDTH(CYC_WIDTH)) u_cyc (
    .clk (clk),
    .clr (rst || xfer),
    .en  (run),
    .q   (cyc)
  );
endmodule
